// File: rtl/onn_pkg.sv
// Shared sizes and FSM encoding for the ONN run controller.
// Optional debug outputs on the top are enabled by defining ONN_CTRL_DBG_EN.
package onn_pkg;

    localparam int N_OSC  = 15;
    localparam int PHW    = 4;
    localparam int PHI_W  = N_OSC * PHW;
    localparam int ROWS   = 5;
    localparam int COLS   = 3;
    localparam int BCNT_W = $clog2(PHI_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_INIT = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } onn_ctrl_state_t;

endpackage

// File: rtl/onn_ser_loader.sv
// Serial-to-parallel pattern loader: MSB-first shift register with a saturating bit count.
module onn_ser_loader
    import onn_pkg::*;
(
    input  logic             clk,
    input  logic             re,
    input  logic             start,
    input  logic             shift_en,
    input  logic             ser_bit,
    output logic [PHI_W-1:0] pattern,
    output logic             full
);

    logic [PHI_W-1:0]  pattern_q, pattern_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign full    = (bit_cnt_q == BCNT_W'(PHI_W));
    assign pattern = pattern_q;

    always_comb begin
        pattern_d = pattern_q;
        bit_cnt_d = bit_cnt_q;
        // The bit on the edge that leaves IDLE is the first bit of the stream.
        if (start) begin
            pattern_d = {pattern_q[PHI_W-2:0], ser_bit};
            bit_cnt_d = BCNT_W'(1);
        end else if (shift_en && !full) begin
            pattern_d = {pattern_q[PHI_W-2:0], ser_bit};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            pattern_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            pattern_q <= pattern_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/onn_run_ctrl.sv
// ONN core sequencer: load pattern, init core, run until phases settle or time out.
// Define ONN_CTRL_DBG_EN to add dbg_run_cycles and dbg_state outputs.
module onn_run_ctrl
    import onn_pkg::*;
#(
    parameter int STABLE_CYC = 8,
    parameter int MAX_CYC    = 1024,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             re,
    input  logic             ser_bit,
    input  logic             load,
    output logic [PHI_W-1:0] core_phi_init,
    output logic             core_init,
    output logic             core_en,
    input  logic [PHI_W-1:0] core_phi,
    input  logic [1:0]       class_num,
    output logic [1:0]       num,
    output logic             done,
    output logic             busy,
    output logic             timeout,
`ifdef ONN_CTRL_DBG_EN
    output logic [CNT_W-1:0] dbg_run_cycles,
    output logic [2:0]       dbg_state,
`endif
    output logic             load_err
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);

    onn_ctrl_state_t   state_q, state_d;
    logic [PHI_W-1:0]  prev_phi_q, prev_phi_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [1:0]        num_q, num_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              load_err_q, load_err_d;

    logic [PHI_W-1:0]  pattern;
    logic              full;
    logic              phi_eq;

    onn_ser_loader u_loader (
        .clk      (clk),
        .re       (re),
        .start    (state_q == ST_IDLE && load),
        .shift_en (state_q == ST_LOAD && load),
        .ser_bit  (ser_bit),
        .pattern  (pattern),
        .full     (full)
    );

    assign phi_eq = (core_phi == prev_phi_q);

    always_comb begin
        state_d    = state_q;
        prev_phi_d = prev_phi_q;
        run_cnt_d  = run_cnt_q;
        stab_cnt_d = stab_cnt_q;
        num_d      = num_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        load_err_d = load_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_LOAD;
                    timeout_d  = 1'b0;
                    load_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!load) begin
                    if (full) begin
                        state_d = ST_INIT;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_INIT: begin
                prev_phi_d = pattern;
                run_cnt_d  = '0;
                stab_cnt_d = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                prev_phi_d = core_phi;
                run_cnt_d  = run_cnt_q + CNT_W'(1);
                stab_cnt_d = phi_eq ? stab_cnt_q + STAB_W'(1) : '0;
                // Convergence is tested first so it wins a tie with the cycle limit.
                if (phi_eq && stab_cnt_q == STAB_W'(STABLE_CYC - 1)) begin
                    state_d = ST_DONE;
                end else if (run_cnt_q == CNT_W'(MAX_CYC - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                num_d   = class_num;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (re) begin
            state_q    <= ST_IDLE;
            prev_phi_q <= '0;
            run_cnt_q  <= '0;
            stab_cnt_q <= '0;
            num_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_phi_q <= prev_phi_d;
            run_cnt_q  <= run_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            num_q      <= num_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            load_err_q <= load_err_d;
        end
    end

    assign core_phi_init = pattern;
    assign core_init     = (state_q == ST_INIT);
    assign core_en       = (state_q == ST_RUN);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_INIT) || (state_q == ST_RUN);
    assign num           = num_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign load_err      = load_err_q;

`ifdef ONN_CTRL_DBG_EN
    logic [CNT_W-1:0] dbg_run_q, dbg_run_d;

    always_comb begin
        dbg_run_d = dbg_run_q;
        if (state_q == ST_DONE) dbg_run_d = run_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (re) dbg_run_q <= '0;
        else    dbg_run_q <= dbg_run_d;
    end

    assign dbg_run_cycles = dbg_run_q;
    assign dbg_state      = state_q;
`endif

endmodule

// File: tb/tb_onn_run_ctrl.sv
// Directed + randomized bench for onn_run_ctrl with a behavioural core and run-length model.
module tb_onn_run_ctrl;

    localparam int PW     = 60;
    localparam int STABLE = 8;
    localparam int MAXC   = 1024;

    logic          clk = 1'b0;
    logic          re = 1'b1;
    logic          ser_bit = 1'b0;
    logic          load = 1'b0;
    logic [PW-1:0] core_phi_init;
    logic          core_init, core_en;
    logic [PW-1:0] core_phi = '0;
    logic [1:0]    class_num;
    logic [1:0]    num;
    logic          done, busy, timeout, load_err;

    int n_tests = 0;
    int n_fail  = 0;
    int tog_req = 0;
    int tog_left = 0;

    onn_run_ctrl dut (
        .clk(clk), .re(re), .ser_bit(ser_bit), .load(load),
        .core_phi_init(core_phi_init), .core_init(core_init), .core_en(core_en),
        .core_phi(core_phi), .class_num(class_num), .num(num), .done(done),
        .busy(busy), .timeout(timeout), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Core model: copies the init vector, then toggles bit 0 on the first tog_req enabled edges.
    always @(posedge clk) begin
        if (core_init) begin
            core_phi <= core_phi_init;
            tog_left <= tog_req;
        end else if (core_en && tog_left > 0) begin
            core_phi <= core_phi ^ 60'h1;
            tog_left <= tog_left - 1;
        end
    end

    function automatic logic [1:0] classify(input logic [PW-1:0] p);
        return p[1:0] ^ p[59:58];
    endfunction

    assign class_num = classify(core_phi);

    // Reference: run cycle j sees the phase toggled min(j-1,K) times; compare with cycle j-1.
    function automatic void ref_run(input int k, output int jend, output bit tmo);
        int consec = 0;
        jend = MAXC;
        tmo  = 1'b1;
        for (int j = 1; j <= MAXC; j++) begin
            int tc = (j - 1 < k) ? j - 1 : k;
            int tp = (j < 2) ? 0 : ((j - 2 < k) ? j - 2 : k);
            consec = (tc == tp) ? consec + 1 : 0;
            if (consec == STABLE) begin
                jend = j;
                tmo  = 1'b0;
                return;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [69:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load    = 1'b1;
            ser_bit = bits[n-1-i];
        end
        @(negedge clk);
        load    = 1'b0;
        ser_bit = 1'b0;
    endtask

    // Loads a stream, expects the init pulse, then the done strobe at the modelled cycle.
    task automatic run_one(input string tag, input logic [69:0] bits, input int n, input int k);
        logic [PW-1:0] pat;
        int jend, cyc;
        bit tmo;
        pat = bits[n-1 -: PW];
        tog_req = k;
        ref_run(k, jend, tmo);
        send(bits, n);
        @(negedge clk);
        chk({tag, "_init"}, 64'(core_init), 64'd1);
        chk({tag, "_phi_init"}, 64'(core_phi_init), 64'(pat));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_lat"}, 64'(cyc), 64'(jend + 2));
        chk({tag, "_num"}, 64'(num), 64'(classify(pat ^ 60'(((jend < k ? jend : k) & 1)))));
        chk({tag, "_timeout"}, 64'(timeout), 64'(tmo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [69:0] bits;
        int saw_init;

        repeat (3) @(negedge clk);
        re = 1'b0;
        chk("rst_outs", 64'({core_init, core_en, num, done, busy, timeout, load_err}), 64'd0);
        chk("rst_phi_init", 64'(core_phi_init), 64'd0);

        bits = '0;
        bits[59:0] = 60'h800000000000000;
        run_one("stable", bits, 60, 0);

        bits = 70'({$urandom, $urandom});
        run_one("tmo", bits, 60, 5000);

        // Short stream: error flagged, no init, back to idle.
        bits = 70'($urandom);
        send(bits, 37);
        @(negedge clk);
        chk("short_err", 64'(load_err), 64'd1);
        chk("short_busy", 64'(busy), 64'd0);
        chk("short_tmo_clr", 64'(timeout), 64'd0);
        saw_init = int'(core_init);
        repeat (5) begin
            @(negedge clk);
            saw_init += int'(core_init);
        end
        chk("short_no_init", 64'(saw_init), 64'd0);

        bits = {6'($urandom), $urandom, $urandom};
        run_one("long70", bits, 70, int'($urandom_range(0, 20)));
        chk("long70_err_clr", 64'(load_err), 64'd0);

        for (int r = 0; r < 4; r++) begin
            bits = 70'({$urandom, $urandom});
            run_one($sformatf("rnd%0d", r), bits, 60, int'($urandom_range(0, 40)));
        end

        // Reset in the middle of a long run.
        tog_req = 5000;
        bits = 70'({$urandom, $urandom});
        send(bits, 60);
        @(negedge clk);
        chk("mid_init", 64'(core_init), 64'd1);
        repeat (6) @(negedge clk);
        chk("mid_running", 64'(core_en), 64'd1);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        chk("mid_rst", 64'({core_en, busy, num, done}), 64'd0);
        saw_init = 0;
        repeat (20) begin
            @(negedge clk);
            saw_init += int'(done) + int'(core_en);
        end
        chk("mid_quiet", 64'(saw_init), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
